// File: rtl/problema1_button_debounce.sv
// Per-channel push-button debouncer: two-flop synchronizer, saturating qualification counter,
// optional one-cycle press/release pulses when DEBOUNCE_EDGE_PULSE_EN is defined.
// release is a reserved word in SystemVerilog, so that output is named release_pulse.
module problema1_button_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] accept;
    logic [CW-1:0]    cnt [WIDTH];

    // A channel is accepted on the cycle its differing level has been seen DEBOUNCE_CYCLES times.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != out_port[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '1;
            sync2    <= '1;
            out_port <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == out_port[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    out_port[i] <= sync2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    // Pulses are registered on the same edge that updates out_port, so they line up with its new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            press         <= '0;
            release_pulse <= '0;
        end else begin
            press         <= accept & ~sync2;
            release_pulse <= accept & sync2;
        end
    end
`else
    assign press         = '0;
    assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_problema1_button_debounce.sv
// Directed bench for problema1_button_debounce with WIDTH=2, DEBOUNCE_CYCLES=4.
// Pulse expectations follow DEBOUNCE_EDGE_PULSE_EN; with it undefined press/release must stay 0.
module tb_problema1_button_debounce;

    localparam int W  = 2;
    localparam int DC = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_port = '1;
    logic [W-1:0] out_port;
    logic [W-1:0] press;
    logic [W-1:0] release_pulse;

    int n_pass  = 0;
    int n_total = 0;

    problema1_button_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_port       (in_port),
        .out_port      (out_port),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        in_port = 2'b11;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_total++;
            if ({out_port, press, release_pulse} !== {2'b11, 2'b00, 2'b00})
                $display("FAIL reset_idle cyc %0d: got out=%b press=%b rel=%b, want out=11 press=00 rel=00",
                         k, out_port, press, release_pulse);
            else
                n_pass++;
        end
    endtask

    task automatic test_clean_press();
        logic [W-1:0] eo, ep, er;
        in_port = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            eo = (k >= 6) ? 2'b10 : 2'b11;
            ep = (PULSE_EN && k == 6) ? 2'b01 : 2'b00;
            n_total++;
            if ({out_port, press, release_pulse} !== {eo, ep, 2'b00})
                $display("FAIL clean_press edge %0d: got out=%b press=%b rel=%b, want out=%b press=%b rel=00",
                         k, out_port, press, release_pulse, eo, ep);
            else
                n_pass++;
        end
        in_port = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            eo = (k >= 6) ? 2'b11 : 2'b10;
            er = (PULSE_EN && k == 6) ? 2'b01 : 2'b00;
            n_total++;
            if ({out_port, press, release_pulse} !== {eo, 2'b00, er})
                $display("FAIL clean_release edge %0d: got out=%b press=%b rel=%b, want out=%b press=00 rel=%b",
                         k, out_port, press, release_pulse, eo, er);
            else
                n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] pattern [10];
        pattern = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
        for (int k = 0; k < 16; k++) begin
            in_port = (k < 10) ? pattern[k] : 2'b11;
            tick();
            n_total++;
            if ({out_port, press, release_pulse} !== {2'b11, 2'b00, 2'b00})
                $display("FAIL bounce edge %0d: got out=%b press=%b rel=%b, want out=11 press=00 rel=00",
                         k + 1, out_port, press, release_pulse);
            else
                n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eo, ep, er;
        in_port = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            tick();
            eo = (k >= 6) ? 2'b00 : 2'b11;
            ep = (PULSE_EN && k == 6) ? 2'b11 : 2'b00;
            n_total++;
            if ({out_port, press, release_pulse} !== {eo, ep, 2'b00})
                $display("FAIL both_press edge %0d: got out=%b press=%b rel=%b, want out=%b press=%b rel=00",
                         k, out_port, press, release_pulse, eo, ep);
            else
                n_pass++;
        end
        in_port = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            eo = (k >= 6) ? 2'b11 : 2'b00;
            er = (PULSE_EN && k == 6) ? 2'b11 : 2'b00;
            n_total++;
            if ({out_port, press, release_pulse} !== {eo, 2'b00, er})
                $display("FAIL both_release edge %0d: got out=%b press=%b rel=%b, want out=%b press=00 rel=%b",
                         k, out_port, press, release_pulse, eo, er);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] eo, ep;
        in_port = 2'b01;
        // Edges 3 and 4 take cnt[1] to 2; reset is sampled on edge 5.
        for (int k = 1; k <= 4; k++) tick();
        reset = 1'b1;
        tick();
        n_total++;
        if ({out_port, press, release_pulse} !== {2'b11, 2'b00, 2'b00})
            $display("FAIL reset_mid during: got out=%b press=%b rel=%b, want out=11 press=00 rel=00",
                     out_port, press, release_pulse);
        else
            n_pass++;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            eo = (k >= 6) ? 2'b01 : 2'b11;
            ep = (PULSE_EN && k == 6) ? 2'b10 : 2'b00;
            n_total++;
            if ({out_port, press, release_pulse} !== {eo, ep, 2'b00})
                $display("FAIL reset_mid edge %0d: got out=%b press=%b rel=%b, want out=%b press=%b rel=00",
                         k, out_port, press, release_pulse, eo, ep);
            else
                n_pass++;
        end
        in_port = 2'b11;
        for (int k = 1; k <= 8; k++) tick();
        n_total++;
        if (out_port !== 2'b11)
            $display("FAIL reset_mid settle: got out=%b, want out=11", out_port);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
